// File: rtl/post_lna_chain.sv
// Bias-sequenced receive/transmit delay chain behind an LNA: an OFF/SETTLE/ACTIVE/DRAIN
// power FSM gates per-lane pipelines. Define POST_LNA_LOOPBACK_EN to add the Loopback port.
module post_lna_chain #(
  parameter int WIDTH    = 8,
  parameter int STAGES   = 4,
  parameter int CHANNELS = 2
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      BiasEnable,
`ifdef POST_LNA_LOOPBACK_EN
  input  logic                      Loopback,
`endif
  input  logic [CHANNELS*WIDTH-1:0] OuterReceive,
  input  logic [CHANNELS-1:0]       OuterReceiveValid,
  output logic [CHANNELS*WIDTH-1:0] InnerReceive,
  output logic [CHANNELS-1:0]       InnerReceiveValid,
  input  logic [CHANNELS*WIDTH-1:0] InnerTransmit,
  input  logic [CHANNELS-1:0]       InnerTransmitValid,
  output logic [CHANNELS*WIDTH-1:0] OuterTransmit,
  output logic [CHANNELS-1:0]       OuterTransmitValid,
  output logic                      Ready,
  output logic [2:0]                BiasState
);

  localparam int CNT_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGES - 1);

  typedef enum logic [2:0] {
    OFF        = 3'd0,
    SETTLE_VSS = 3'd1,
    SETTLE_VDD = 3'd2,
    ACTIVE     = 3'd3,
    DRAIN      = 3'd4
  } biasState_t;

  biasState_t       state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;

  logic [CHANNELS*WIDTH-1:0] rxData_p [STAGES];
  logic [CHANNELS-1:0]       rxVld_p  [STAGES];
  logic [CHANNELS*WIDTH-1:0] txData_p [STAGES];
  logic [CHANNELS-1:0]       txVld_p  [STAGES];

  logic [CHANNELS*WIDTH-1:0] txInData;
  logic [CHANNELS-1:0]       txInVld;

  // Control: bias FSM, shared dwell counter and registered Ready
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= OFF;
      cnt   <= '0;
      Ready <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      Ready <= (stateNext == ACTIVE);
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt + CNT_W'(1);
    case (state)
      OFF: begin
        if (BiasEnable) stateNext = SETTLE_VSS;
      end
      SETTLE_VSS: begin
        if (!BiasEnable)           stateNext = OFF;
        else if (cnt == CNT_LAST)  stateNext = SETTLE_VDD;
      end
      SETTLE_VDD: begin
        if (!BiasEnable)           stateNext = OFF;
        else if (cnt == CNT_LAST)  stateNext = ACTIVE;
      end
      ACTIVE: begin
        if (!BiasEnable) stateNext = DRAIN;
      end
      DRAIN: begin
        // A new BiasEnable request waits until OFF is reached.
        if (cnt == CNT_LAST) stateNext = OFF;
      end
      default: stateNext = OFF;
    endcase
    // Counter restarts on every state change and idles at zero outside timed states.
    if (stateNext != state || state == OFF || state == ACTIVE) cntNext = '0;
  end

  assign BiasState = state;

`ifdef POST_LNA_LOOPBACK_EN
  assign txInData = Loopback ? InnerReceive      : InnerTransmit;
  assign txInVld  = Loopback ? InnerReceiveValid : InnerTransmitValid;
`else
  assign txInData = InnerTransmit;
  assign txInVld  = InnerTransmitValid;
`endif

  // Stage 0 .. STAGES-1: data shifts freely; valid is gated by Ready at entry
  always_ff @(posedge Clk) begin
    rxData_p[0] <= OuterReceive;
    txData_p[0] <= txInData;
    for (int s = 1; s < STAGES; s++) begin
      rxData_p[s] <= rxData_p[s-1];
      txData_p[s] <= txData_p[s-1];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int s = 0; s < STAGES; s++) begin
        rxVld_p[s] <= '0;
        txVld_p[s] <= '0;
      end
    end else begin
      rxVld_p[0] <= OuterReceiveValid & {CHANNELS{Ready}};
      txVld_p[0] <= txInVld & {CHANNELS{Ready}};
      for (int s = 1; s < STAGES; s++) begin
        rxVld_p[s] <= rxVld_p[s-1];
        txVld_p[s] <= txVld_p[s-1];
      end
    end
  end

  // Output taps
  assign InnerReceive       = rxData_p[STAGES-1];
  assign InnerReceiveValid  = rxVld_p[STAGES-1];
  assign OuterTransmit      = txData_p[STAGES-1];
  assign OuterTransmitValid = txVld_p[STAGES-1];

endmodule
